gcd_dispatch: RTL

Upstream job dispatcher for the GCD core. It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It issues each pair to the core with a one-cycle start pulse, waits for the core's done pulse, and presents the result with its operands on a valid/ready output stream. Zero operands bypass the core, and a watchdog flags a core that never answers.

---
 rtl/gcd_pkg.sv | 18 +
 rtl/gcd_fifo.sv | 55 +++++
 rtl/gcd_dispatch.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types for the GCD job dispatcher: FSM states, default width, operand pair.
package gcd_pkg;

    localparam int unsigned DefWidth = 5;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StHold
    } state_e;

    typedef struct packed {
        logic [DefWidth-1:0] a;
        logic [DefWidth-1:0] b;
    } pair_t;

endpackage

// File: rtl/gcd_fifo.sv
// Synchronous FIFO with registered occupancy count and asynchronous active-low reset.
module gcd_fifo #(
    parameter int unsigned DWIDTH = 10,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DWIDTH-1:0]          wdata,
    output logic [DWIDTH-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == (PtrW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset; reset empties the FIFO through the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/gcd_dispatch.sv
// Job dispatcher in front of the GCD core: buffers operand pairs, runs one job at a time,
// bypasses zero operands and flags a core that never answers.
module gcd_dispatch
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_err,
    output logic             busy
);

    localparam int unsigned          WdWidth = $clog2(TIMEOUT + 1);
    localparam logic [WdWidth-1:0]   WdMax   = WdWidth'(TIMEOUT);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 err_q, err_d;
    logic [WdWidth-1:0]   wdog_q, wdog_d;

    logic                 fifo_pop;
    logic [2*WIDTH-1:0]   fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [WIDTH-1:0]     head_a;
    logic [WIDTH-1:0]     head_b;

    gcd_fifo #(
        .DWIDTH (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .pop   (fifo_pop),
        .wdata ({in_a, in_b}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {head_a, head_b} = fifo_rdata;
    assign in_ready         = !fifo_full;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        err_d    = err_q;
        wdog_d   = wdog_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    a_d      = head_a;
                    b_d      = head_b;
                    err_d    = 1'b0;
                    // gcd(x,0) = x and gcd(0,0) = 0, so a | b is the answer without the core.
                    if (head_a == '0 || head_b == '0) begin
                        res_d   = head_a | head_b;
                        state_d = StHold;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                wdog_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                if (gcd_done) begin
                    res_d   = gcd_res;
                    state_d = StHold;
                end else if (wdog_q == WdMax) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = StHold;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StHold: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
        end
    end

    assign gcd_start = (state_q == StIssue);
    assign gcd_a     = a_q;
    assign gcd_b     = b_q;
    assign out_valid = (state_q == StHold);
    assign out_res   = res_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_err   = err_q;
    assign busy      = (fifo_count != '0) || (state_q != StIdle);

endmodule
